datapath_input: RTL

// - CPU-to-DMAC write path, the counterpart of the CPU read-out path.
// - Captures CPU write data from the 32-bit CPU data bus and holds it for the FIFO/SCSI side.
// - On a 16-bit bridged port, packs two upper-lane words into one longword.
// - Presents the result as a single-entry valid/ack holding register.
// - Stretches the CPU cycle via ACCEPT when the register is still occupied.

---
 rtl/dmac_pkg.sv | 26 ++
 rtl/strobe_edge.sv | 40 ++++
 rtl/datapath_input.sv | 119 +++++++++++
 3 files changed

// File: rtl/dmac_pkg.sv
// Shared types, widths and lane-packing helpers for the DMAC CPU write path.
package dmac_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned LONG_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PACK1 = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Join two bridged words into a longword; upper_first puts the first word in [31:16].
  function automatic logic [LONG_W-1:0] pack_pair(input logic [WORD_W-1:0] first,
                                                  input logic [WORD_W-1:0] second,
                                                  input logic              upper_first);
    return upper_first ? {first, second} : {second, first};
  endfunction

  // Push out a lone first word in its own lane, the partner lane zero-filled.
  function automatic logic [LONG_W-1:0] pack_lone(input logic [WORD_W-1:0] first,
                                                  input logic              upper_first);
    return upper_first ? {first, {WORD_W{1'b0}}} : {{WORD_W{1'b0}}, first};
  endfunction

endpackage

// File: rtl/strobe_edge.sv
// CPU strobe edge detector: turns a level strobe into one pending capture request
// and flags strobes that end before their data could be captured.
module strobe_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_stb,
  input  logic taken,
  output logic pending_c,
  output logic overrun
);

  logic stb_q;
  logic pend_q;
  logic rise;

  assign rise      = cpu_stb & ~stb_q;
  assign pending_c = pend_q & cpu_stb;

  // Track the strobe level, arm on a rising edge, disarm on capture or early drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_q   <= 1'b0;
      pend_q  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      stb_q <= cpu_stb;
      if (pend_q) begin
        if (!cpu_stb) begin
          pend_q  <= 1'b0;
          overrun <= 1'b1;
        end else if (taken) begin
          pend_q <= 1'b0;
        end
      end else if (rise) begin
        pend_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/datapath_input.sv
// CPU-to-DMAC write path: captures CPU write data (optionally packing two 16-bit
// bridged words) into a single-entry valid/ack holding register.
module datapath_input
  import dmac_pkg::*;
#(
  parameter bit UPPER_FIRST = 1'b1,
  parameter bit PASS_ON_ACK = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET_,
  input  logic [LONG_W-1:0] DATA_IN,
  input  logic              CPU_STB,
  input  logic              BRIDGEIN,
  input  logic              FLUSH,
  output logic [LONG_W-1:0] ID,
  output logic              ID_VALID,
  input  logic              ID_ACK,
  output logic              ACCEPT,
  output logic              HALF,
  output logic              OVERRUN
);

  state_t              state_q, state_d;
  logic [LONG_W-1:0]   id_d;
  logic                valid_d;
  logic [WORD_W-1:0]   pack_q, pack_d;
  logic [WORD_W-1:0]   hi_word;
  logic                pending_c;
  logic                take_c;

  assign hi_word = DATA_IN[LONG_W-1 -: WORD_W];

  strobe_edge u_strobe_edge (
    .clk       (CLK),
    .rst_n     (RESET_),
    .cpu_stb   (CPU_STB),
    .taken     (take_c),
    .pending_c (pending_c),
    .overrun   (OVERRUN)
  );

  // Packing FSM: decide the capture, the next holding-register contents and next state.
  always_comb begin
    state_d = state_q;
    id_d    = ID;
    valid_d = ID_VALID;
    pack_d  = pack_q;
    take_c  = 1'b0;
    case (state_q)
      EMPTY: begin
        if (pending_c) begin
          take_c = 1'b1;
          if (BRIDGEIN) begin
            pack_d  = hi_word;
            state_d = PACK1;
          end else begin
            id_d    = DATA_IN;
            valid_d = 1'b1;
            state_d = FULL;
          end
        end
      end
      PACK1: begin
        if (pending_c && BRIDGEIN) begin
          take_c  = 1'b1;
          id_d    = pack_pair(pack_q, hi_word, UPPER_FIRST);
          valid_d = 1'b1;
          state_d = FULL;
        end else if (pending_c || FLUSH) begin
          // A 32-bit write cannot join a half pack: push the half out, retry the write later.
          id_d    = pack_lone(pack_q, UPPER_FIRST);
          valid_d = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (ID_ACK) begin
          valid_d = 1'b0;
          state_d = EMPTY;
          if (PASS_ON_ACK && pending_c) begin
            take_c = 1'b1;
            if (BRIDGEIN) begin
              pack_d  = hi_word;
              state_d = PACK1;
            end else begin
              id_d    = DATA_IN;
              valid_d = 1'b1;
              state_d = FULL;
            end
          end
        end
      end
      default: begin
        state_d = EMPTY;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, holding register and registered status outputs.
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      state_q  <= EMPTY;
      ID       <= '0;
      ID_VALID <= 1'b0;
      pack_q   <= '0;
      ACCEPT   <= 1'b0;
      HALF     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ID       <= id_d;
      ID_VALID <= valid_d;
      pack_q   <= pack_d;
      ACCEPT   <= take_c;
      HALF     <= (state_d == PACK1);
    end
  end

endmodule
